// File: rtl/johnson_sequencer.sv
// ---------------------------------------------------------------------------
// johnson_sequencer
//
// Bidirectional shift-sequence generator. At run time it can be a Johnson
// (twisted-ring, 2*WIDTH states) counter or a ring (one-hot, WIDTH states)
// counter. It also provides:
//   - a synchronous load,
//   - detection and self-correction of illegal states,
//   - a binary phase index,
//   - a terminal-count strobe.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (count -> home, err -> 0)
//   enable      advance one step this cycle
//   dir         1 = forward (shift right), 0 = reverse (shift left)
//   mode        0 = Johnson, 1 = ring
//   load        synchronous load of load_value; overrides enable
//   load_value  value to load (an illegal value loads home and flags err)
//   count       registered sequence state
//   phase       binary position of count within the current mode's sequence
//   legal       count is a legal state for the current mode
//   tc          next advance wraps through phase 0
//   err         one-cycle registered pulse after a correcting edge
// ---------------------------------------------------------------------------
module johnson_sequencer #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             legal,
  output logic             tc,
  output logic             err
);

  // Home state is legal in both modes and is phase 0 in both.
  localparam logic [WIDTH-1:0] HOME   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]    LAST_J = PW'(2*WIDTH-1);
  localparam logic [PW-1:0]    LAST_R = PW'(WIDTH-1);

  logic [WIDTH-1:0] r_count;
  logic             r_err;
  logic             w_legal;
  logic [PW-1:0]    w_phase;
  logic [PW-1:0]    w_last;
  logic [WIDTH-1:0] w_next;
  logic             w_load_ok;

  // Number of set bits in v.
  function automatic int f_ones(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  // Legality check.
  //   Johnson: at most one transition between adjacent bits.
  //   Ring:    exactly one bit set.
  function automatic logic f_legal(input logic [WIDTH-1:0] v, input logic m);
    int trans;
    logic ok;
    trans = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      if (v[i+1] != v[i]) trans = trans + 1;
    end
    if (m) ok = (f_ones(v) == 1);
    else   ok = (trans <= 1);
    return ok;
  endfunction

  // Phase index within the current mode's sequence; 0 for an illegal state.
  // Johnson states with MSB=1 form the fill half (ones-1). States with
  // MSB=0 form the drain half (WIDTH+zeros-1).
  function automatic logic [PW-1:0] f_phase(input logic [WIDTH-1:0] v,
                                            input logic m);
    int ones;
    int idx;
    ones = f_ones(v);
    idx  = 0;
    if (f_legal(v, m)) begin
      if (m) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (v[WIDTH-1-i]) idx = i;
        end
      end else if (v[WIDTH-1]) begin
        idx = ones - 1;
      end else begin
        idx = WIDTH + (WIDTH - ones) - 1;
      end
    end
    return PW'(idx);
  endfunction

  // One step of the sequence. The bit fed back is inverted in Johnson mode
  // and passed straight through in ring mode.
  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] v,
                                               input logic d,
                                               input logic m);
    logic [WIDTH-1:0] nv;
    if (d) nv = {(m ? v[0] : ~v[0]), v[WIDTH-1:1]};
    else   nv = {v[WIDTH-2:0], (m ? v[WIDTH-1] : ~v[WIDTH-1])};
    return nv;
  endfunction

  always_comb begin
    w_legal   = f_legal(r_count, mode);
    w_phase   = f_phase(r_count, mode);
    w_last    = mode ? LAST_R : LAST_J;
    w_next    = f_next(r_count, dir, mode);
    w_load_ok = f_legal(load_value, mode);
  end

  // State update. Priority: load, then correction, then advance, then hold.
  // An illegal count with enable=0 simply holds; it is corrected only when
  // the sequencer is next asked to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= HOME;
      r_err   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_ok ? load_value : HOME;
      r_err   <= ~w_load_ok;
    end else if (enable) begin
      r_count <= w_legal ? w_next : HOME;
      r_err   <= ~w_legal;
    end else begin
      r_err   <= 1'b0;
    end
  end

  assign count = r_count;
  assign err   = r_err;
  assign legal = w_legal;
  assign phase = w_phase;
  // Wrap point: last phase going forward, phase 0 going in reverse.
  assign tc    = enable & ~load & w_legal &
                 (dir ? (w_phase == w_last) : (w_phase == '0));

endmodule
